// File: rtl/host_slv_demux.sv
// host_slv_demux: routes the host AXI slave port by address to mem (port 0) or reg (port 1), locking each direction to one target; ports clk_i, rst_i, host_req_i/host_resp_o, mem_req_o/mem_resp_i, reg_req_o/reg_resp_i
package host_slv_demux_pkg;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned UW = 1;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [UW-1:0] user;
  } ax_chan_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [DW/8-1:0] strb;
    logic last;
    logic [UW-1:0] user;
  } w_chan_t;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0] resp;
    logic [UW-1:0] user;
  } b_chan_t;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0] resp;
    logic last;
    logic [UW-1:0] user;
  } r_chan_t;
  typedef struct packed {
    ax_chan_t aw;
    logic aw_valid;
    w_chan_t w;
    logic w_valid;
    logic b_ready;
    ax_chan_t ar;
    logic ar_valid;
    logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    b_chan_t b;
    logic b_valid;
    r_chan_t r;
    logic r_valid;
  } resp_t;
endpackage

module host_slv_demux #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth = 4,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned MaxTxns = 8,
  parameter logic [AddrWidth-1:0] RegBase = 32'h1A00_0000,
  parameter logic [AddrWidth-1:0] RegSize = 32'h0010_0000,
  parameter type req_t = host_slv_demux_pkg::req_t,
  parameter type resp_t = host_slv_demux_pkg::resp_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  req_t  host_req_i,
  output resp_t host_resp_o,
  output req_t  mem_req_o,
  input  resp_t mem_resp_i,
  output req_t  reg_req_o,
  input  resp_t reg_resp_i
);
  localparam int unsigned CW = $clog2(MaxTxns + 1);
  localparam int unsigned PW = MaxTxns > 1 ? $clog2(MaxTxns) : 1;
  localparam logic [CW-1:0] MaxCnt = CW'(MaxTxns);
  localparam logic [PW-1:0] LastPtr = PW'(MaxTxns - 1);
  function automatic logic in_reg(input logic [AddrWidth-1:0] a);
    return ({1'b0, a} >= {1'b0, RegBase}) && ({1'b0, a} < ({1'b0, RegBase} + {1'b0, RegSize}));
  endfunction
  logic r_en, r_wsel, r_rsel;
  logic [CW-1:0] r_wcnt, r_rcnt, r_fcnt;
  logic [MaxTxns-1:0] r_fifo;
  logic [PW-1:0] r_wp, r_rp;
  logic w_en, w_aw_sel, w_ar_sel, w_aw_ok, w_ar_ok, w_fempty, w_head;
  logic w_aw_hs, w_wl_hs, w_b_hs, w_ar_hs, w_rl_hs;
  assign w_en = r_en & ~rst_i;
  assign w_aw_sel = in_reg(host_req_i.aw.addr);
  assign w_ar_sel = in_reg(host_req_i.ar.addr);
  assign w_aw_ok = w_en && (r_wcnt == '0 || r_wsel == w_aw_sel) && r_wcnt < MaxCnt && r_fcnt < MaxCnt;
  assign w_ar_ok = w_en && (r_rcnt == '0 || r_rsel == w_ar_sel) && r_rcnt < MaxCnt;
  assign w_fempty = r_fcnt == '0;
  assign w_head = r_fifo[r_rp];
  always_comb begin
    mem_req_o = host_req_i;
    reg_req_o = host_req_i;
    mem_req_o.aw_valid = host_req_i.aw_valid & w_aw_ok & ~w_aw_sel;
    reg_req_o.aw_valid = host_req_i.aw_valid & w_aw_ok & w_aw_sel;
    mem_req_o.w_valid = host_req_i.w_valid & w_en & ~w_fempty & ~w_head;
    reg_req_o.w_valid = host_req_i.w_valid & w_en & ~w_fempty & w_head;
    mem_req_o.b_ready = host_req_i.b_ready & w_en & ~r_wsel;
    reg_req_o.b_ready = host_req_i.b_ready & w_en & r_wsel;
    mem_req_o.ar_valid = host_req_i.ar_valid & w_ar_ok & ~w_ar_sel;
    reg_req_o.ar_valid = host_req_i.ar_valid & w_ar_ok & w_ar_sel;
    mem_req_o.r_ready = host_req_i.r_ready & w_en & ~r_rsel;
    reg_req_o.r_ready = host_req_i.r_ready & w_en & r_rsel;
    host_resp_o = r_wsel ? reg_resp_i : mem_resp_i;
    host_resp_o.r = r_rsel ? reg_resp_i.r : mem_resp_i.r;
    host_resp_o.aw_ready = w_aw_ok & (w_aw_sel ? reg_resp_i.aw_ready : mem_resp_i.aw_ready);
    host_resp_o.w_ready = w_en & ~w_fempty & (w_head ? reg_resp_i.w_ready : mem_resp_i.w_ready);
    host_resp_o.b_valid = w_en & (r_wsel ? reg_resp_i.b_valid : mem_resp_i.b_valid);
    host_resp_o.ar_ready = w_ar_ok & (w_ar_sel ? reg_resp_i.ar_ready : mem_resp_i.ar_ready);
    host_resp_o.r_valid = w_en & (r_rsel ? reg_resp_i.r_valid : mem_resp_i.r_valid);
  end
  assign w_aw_hs = host_req_i.aw_valid & host_resp_o.aw_ready;
  assign w_wl_hs = host_req_i.w_valid & host_resp_o.w_ready & host_req_i.w.last;
  assign w_b_hs = host_resp_o.b_valid & host_req_i.b_ready;
  assign w_ar_hs = host_req_i.ar_valid & host_resp_o.ar_ready;
  assign w_rl_hs = host_resp_o.r_valid & host_req_i.r_ready & host_resp_o.r.last;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en <= 1'b0;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
      r_wcnt <= '0;
      r_rcnt <= '0;
      r_fcnt <= '0;
      r_fifo <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_aw_hs) begin
        r_wsel <= w_aw_sel;
        r_fifo[r_wp] <= w_aw_sel;
        r_wp <= r_wp == LastPtr ? '0 : r_wp + 1'b1;
      end
      if (w_wl_hs) r_rp <= r_rp == LastPtr ? '0 : r_rp + 1'b1;
      if (w_ar_hs) r_rsel <= w_ar_sel;
      r_fcnt <= r_fcnt + CW'(w_aw_hs) - CW'(w_wl_hs);
      r_wcnt <= r_wcnt + CW'(w_aw_hs) - CW'(w_b_hs);
      r_rcnt <= r_rcnt + CW'(w_ar_hs) - CW'(w_rl_hs);
      assert (!(w_b_hs && r_wcnt == '0));
      assert (!(w_rl_hs && r_rcnt == '0));
      assert ($bits(host_req_i.aw.id) == IdWidth && $bits(host_req_i.w.data) == DataWidth && $bits(host_req_i.aw.user) == UserWidth);
    end
  end
endmodule

// File: tb/tb_host_slv_demux.sv
// tb_host_slv_demux: directed self-checking bench for host_slv_demux
module tb_host_slv_demux;
  import host_slv_demux_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  req_t host_req, mem_req, reg_req;
  resp_t host_resp, mem_resp, reg_resp;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  host_slv_demux dut (
    .clk_i(clk),
    .rst_i(rst),
    .host_req_i(host_req),
    .host_resp_o(host_resp),
    .mem_req_o(mem_req),
    .mem_resp_i(mem_resp),
    .reg_req_o(reg_req),
    .reg_resp_i(reg_resp)
  );
  function automatic logic [14:0] outs();
    return {mem_req.aw_valid, mem_req.w_valid, mem_req.ar_valid, mem_req.b_ready, mem_req.r_ready,
            reg_req.aw_valid, reg_req.w_valid, reg_req.ar_valid, reg_req.b_ready, reg_req.r_ready,
            host_resp.aw_ready, host_resp.w_ready, host_resp.ar_ready, host_resp.b_valid, host_resp.r_valid};
  endfunction
  task automatic aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    host_req.aw.addr = a;
    host_req.aw.id = id;
    host_req.aw.len = len;
    host_req.aw_valid = 1'b1;
  endtask
  task automatic ar(input logic [31:0] a, input logic [3:0] id);
    host_req.ar.addr = a;
    host_req.ar.id = id;
    host_req.ar.len = 8'd0;
    host_req.ar_valid = 1'b1;
  endtask
  task automatic wb(input logic [63:0] d, input logic last);
    host_req.w.data = d;
    host_req.w.last = last;
    host_req.w_valid = 1'b1;
  endtask
  task automatic idle();
    host_req.aw_valid = 1'b0;
    host_req.w_valid = 1'b0;
    host_req.ar_valid = 1'b0;
    mem_resp.b_valid = 1'b0;
    mem_resp.r_valid = 1'b0;
    reg_resp.b_valid = 1'b0;
    reg_resp.r_valid = 1'b0;
  endtask
  task automatic test_reset();
    host_req = '0;
    mem_resp = '0;
    reg_resp = '0;
    host_req.b_ready = 1'b1;
    host_req.r_ready = 1'b1;
    mem_resp.aw_ready = 1'b1; mem_resp.w_ready = 1'b1; mem_resp.ar_ready = 1'b1;
    reg_resp.aw_ready = 1'b1; reg_resp.w_ready = 1'b1; reg_resp.ar_ready = 1'b1;
    host_req.aw_valid = 1'b1; host_req.w_valid = 1'b1; host_req.ar_valid = 1'b1;
    mem_resp.b_valid = 1'b1; mem_resp.r_valid = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (outs() !== 15'h0) begin bad++; $display("FAIL reset_hold got=%h exp=0", outs()); end
    rst = 1'b0;
    #1;
    total++; if (outs() !== 15'h0) begin bad++; $display("FAIL reset_first_cycle got=%h exp=0", outs()); end
    total++; if ({dut.r_wcnt, dut.r_rcnt, dut.r_fcnt} !== 12'h0) begin bad++; $display("FAIL reset_counters got=%h exp=0", {dut.r_wcnt, dut.r_rcnt, dut.r_fcnt}); end
    idle();
  endtask
  task automatic test_routing();
    @(negedge clk); aw(32'h1A00_0040, 4'd3, 8'd0); #1;
    total++; if ({reg_req.aw_valid, mem_req.aw_valid, host_resp.aw_ready} !== 3'b101) begin bad++; $display("FAIL rt_aw got=%b exp=101", {reg_req.aw_valid, mem_req.aw_valid, host_resp.aw_ready}); end
    total++; if (reg_req.aw.addr !== 32'h1A00_0040) begin bad++; $display("FAIL rt_aw_addr got=%h exp=1a000040", reg_req.aw.addr); end
    @(negedge clk); host_req.aw_valid = 1'b0; wb(64'hDEAD_BEEF_0000_0001, 1'b1); #1;
    total++; if ({reg_req.w_valid, mem_req.w_valid, host_resp.w_ready} !== 3'b101) begin bad++; $display("FAIL rt_w got=%b exp=101", {reg_req.w_valid, mem_req.w_valid, host_resp.w_ready}); end
    total++; if (reg_req.w.data !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL rt_w_data got=%h exp=deadbeef00000001", reg_req.w.data); end
    @(negedge clk); host_req.w_valid = 1'b0; reg_resp.b_valid = 1'b1; reg_resp.b.id = 4'd3; #1;
    total++; if ({host_resp.b_valid, reg_req.b_ready, mem_req.b_ready} !== 3'b110) begin bad++; $display("FAIL rt_b got=%b exp=110", {host_resp.b_valid, reg_req.b_ready, mem_req.b_ready}); end
    total++; if (host_resp.b.id !== 4'd3) begin bad++; $display("FAIL rt_b_id got=%h exp=3", host_resp.b.id); end
    @(negedge clk); reg_resp.b_valid = 1'b0; ar(32'h1C00_0000, 4'd5); #1;
    total++; if (dut.r_wcnt !== 4'd0) begin bad++; $display("FAIL rt_wcnt got=%0d exp=0", dut.r_wcnt); end
    total++; if ({mem_req.ar_valid, reg_req.ar_valid, host_resp.ar_ready} !== 3'b101) begin bad++; $display("FAIL rt_ar got=%b exp=101", {mem_req.ar_valid, reg_req.ar_valid, host_resp.ar_ready}); end
    @(negedge clk); host_req.ar_valid = 1'b0; mem_resp.r_valid = 1'b1; mem_resp.r.id = 4'd5; mem_resp.r.last = 1'b1; mem_resp.r.data = 64'h1234_5678; #1;
    total++; if ({host_resp.r_valid, mem_req.r_ready, reg_req.r_ready} !== 3'b110) begin bad++; $display("FAIL rt_r got=%b exp=110", {host_resp.r_valid, mem_req.r_ready, reg_req.r_ready}); end
    total++; if ({host_resp.r.id, host_resp.r.data} !== {4'd5, 64'h1234_5678}) begin bad++; $display("FAIL rt_r_fields got=%h/%h exp=5/12345678", host_resp.r.id, host_resp.r.data); end
    @(negedge clk); mem_resp.r_valid = 1'b0; #1;
    total++; if (dut.r_rcnt !== 4'd0) begin bad++; $display("FAIL rt_rcnt got=%0d exp=0", dut.r_rcnt); end
  endtask
  task automatic test_lock();
    @(negedge clk); aw(32'h0000_1000, 4'd1, 8'd0); #1;
    total++; if ({mem_req.aw_valid, reg_req.aw_valid, host_resp.aw_ready} !== 3'b101) begin bad++; $display("FAIL lk_aw_mem got=%b exp=101", {mem_req.aw_valid, reg_req.aw_valid, host_resp.aw_ready}); end
    @(negedge clk); aw(32'h1A00_0100, 4'd2, 8'd0); wb(64'h11, 1'b1); #1;
    total++; if ({reg_req.aw_valid, mem_req.aw_valid, host_resp.aw_ready} !== 3'b000) begin bad++; $display("FAIL lk_aw_held got=%b exp=000", {reg_req.aw_valid, mem_req.aw_valid, host_resp.aw_ready}); end
    total++; if ({mem_req.w_valid, reg_req.w_valid, host_resp.w_ready} !== 3'b101) begin bad++; $display("FAIL lk_w_mem got=%b exp=101", {mem_req.w_valid, reg_req.w_valid, host_resp.w_ready}); end
    @(negedge clk); host_req.w_valid = 1'b0; mem_resp.b_valid = 1'b1; mem_resp.b.id = 4'd1; #1;
    total++; if ({reg_req.aw_valid, host_resp.aw_ready, host_resp.b_valid, mem_req.b_ready} !== 4'b0011) begin bad++; $display("FAIL lk_held_with_b got=%b exp=0011", {reg_req.aw_valid, host_resp.aw_ready, host_resp.b_valid, mem_req.b_ready}); end
    total++; if (dut.r_wcnt !== 4'd1) begin bad++; $display("FAIL lk_wcnt1 got=%0d exp=1", dut.r_wcnt); end
    @(negedge clk); mem_resp.b_valid = 1'b0; #1;
    total++; if ({dut.r_wcnt, reg_req.aw_valid, host_resp.aw_ready} !== {4'd0, 2'b11}) begin bad++; $display("FAIL lk_aw_reg got=%b exp=000011", {dut.r_wcnt, reg_req.aw_valid, host_resp.aw_ready}); end
    @(negedge clk); host_req.aw_valid = 1'b0; wb(64'h22, 1'b1); #1;
    total++; if ({reg_req.w_valid, mem_req.w_valid} !== 2'b10) begin bad++; $display("FAIL lk_w_reg got=%b exp=10", {reg_req.w_valid, mem_req.w_valid}); end
    @(negedge clk); host_req.w_valid = 1'b0; reg_resp.b_valid = 1'b1;
    @(negedge clk); reg_resp.b_valid = 1'b0; #1;
    total++; if (dut.r_wcnt !== 4'd0) begin bad++; $display("FAIL lk_wcnt_end got=%0d exp=0", dut.r_wcnt); end
  endtask
  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); ar(32'h0000_0100, 4'd7); #1;
      total++; if (host_resp.ar_ready !== 1'b1) begin bad++; $display("FAIL fl_ar%0d got=%b exp=1", i, host_resp.ar_ready); end
    end
    @(negedge clk); #1;
    total++; if ({dut.r_rcnt, host_resp.ar_ready, mem_req.ar_valid} !== {4'd8, 2'b00}) begin bad++; $display("FAIL fl_stall got=%b exp=100000", {dut.r_rcnt, host_resp.ar_ready, mem_req.ar_valid}); end
    @(negedge clk); mem_resp.r_valid = 1'b1; mem_resp.r.last = 1'b1; mem_resp.r.id = 4'd7; #1;
    total++; if ({host_resp.ar_ready, host_resp.r_valid} !== 2'b01) begin bad++; $display("FAIL fl_stall_r got=%b exp=01", {host_resp.ar_ready, host_resp.r_valid}); end
    @(negedge clk); mem_resp.r_valid = 1'b0; #1;
    total++; if ({dut.r_rcnt, host_resp.ar_ready, mem_req.ar_valid} !== {4'd7, 2'b11}) begin bad++; $display("FAIL fl_ar9 got=%b exp=011111", {dut.r_rcnt, host_resp.ar_ready, mem_req.ar_valid}); end
    @(negedge clk); host_req.ar_valid = 1'b0; #1;
    total++; if (dut.r_rcnt !== 4'd8) begin bad++; $display("FAIL fl_rcnt8 got=%0d exp=8", dut.r_rcnt); end
    mem_resp.r_valid = 1'b1;
    repeat (8) @(negedge clk);
    mem_resp.r_valid = 1'b0; #1;
    total++; if (dut.r_rcnt !== 4'd0) begin bad++; $display("FAIL fl_drain got=%0d exp=0", dut.r_rcnt); end
  endtask
  task automatic test_w_order();
    @(negedge clk); aw(32'h0000_2000, 4'd1, 8'd3); wb(64'd1, 1'b0); #1;
    total++; if ({host_resp.w_ready, mem_req.w_valid, host_resp.aw_ready} !== 3'b001) begin bad++; $display("FAIL wo_no_bypass got=%b exp=001", {host_resp.w_ready, mem_req.w_valid, host_resp.aw_ready}); end
    @(negedge clk); aw(32'h0000_3000, 4'd2, 8'd1); #1;
    total++; if ({mem_req.w_valid, reg_req.w_valid, host_resp.w_ready, host_resp.aw_ready} !== 4'b1011) begin bad++; $display("FAIL wo_beat1 got=%b exp=1011", {mem_req.w_valid, reg_req.w_valid, host_resp.w_ready, host_resp.aw_ready}); end
    for (int b = 2; b <= 6; b++) begin
      @(negedge clk); host_req.aw_valid = 1'b0; wb(64'(b), b == 4 || b == 6); #1;
      total++; if ({mem_req.w_valid, reg_req.w_valid, host_resp.w_ready, mem_req.w.data} !== {3'b101, 64'(b)}) begin bad++; $display("FAIL wo_beat%0d got=%b/%0d exp=101/%0d", b, {mem_req.w_valid, reg_req.w_valid, host_resp.w_ready}, mem_req.w.data, b); end
      if (b == 2) begin total++; if (dut.r_wcnt !== 4'd2) begin bad++; $display("FAIL wo_wcnt got=%0d exp=2", dut.r_wcnt); end end
      if (b == 5) begin total++; if (dut.r_fcnt !== 4'd1) begin bad++; $display("FAIL wo_fifo2 got=%0d exp=1", dut.r_fcnt); end end
    end
    @(negedge clk); #1;
    total++; if ({host_resp.w_ready, mem_req.w_valid} !== 2'b00) begin bad++; $display("FAIL wo_empty got=%b exp=00", {host_resp.w_ready, mem_req.w_valid}); end
    host_req.w_valid = 1'b0; mem_resp.b_valid = 1'b1;
    repeat (2) @(negedge clk);
    mem_resp.b_valid = 1'b0; #1;
    total++; if (dut.r_wcnt !== 4'd0) begin bad++; $display("FAIL wo_wcnt_end got=%0d exp=0", dut.r_wcnt); end
  endtask
  task automatic test_window();
    logic [31:0] addrs [4];
    logic exp [4];
    addrs = '{32'h19FF_FFFF, 32'h1A00_0000, 32'h1A0F_FFFF, 32'h1A10_0000};
    exp = '{1'b0, 1'b1, 1'b1, 1'b0};
    mem_resp.ar_ready = 1'b0;
    reg_resp.ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ar(addrs[i], 4'd0); #1;
      total++; if ({reg_req.ar_valid, mem_req.ar_valid} !== {exp[i], ~exp[i]}) begin bad++; $display("FAIL win_%h got=%b exp=%b", addrs[i], {reg_req.ar_valid, mem_req.ar_valid}, {exp[i], ~exp[i]}); end
    end
    @(negedge clk); host_req.ar_valid = 1'b0;
    mem_resp.ar_ready = 1'b1;
    reg_resp.ar_ready = 1'b1;
  endtask
  task automatic test_reset_mid();
    @(negedge clk); aw(32'h1A00_0000, 4'd4, 8'd3);
    @(negedge clk); host_req.aw_valid = 1'b0; wb(64'd1, 1'b0);
    @(negedge clk); wb(64'd2, 1'b0); rst = 1'b1; #1;
    total++; if (outs() !== 15'h0) begin bad++; $display("FAIL rm_during got=%h exp=0", outs()); end
    @(negedge clk); rst = 1'b0; aw(32'h1A00_0200, 4'd5, 8'd0); #1;
    total++; if (outs() !== 15'h0) begin bad++; $display("FAIL rm_first got=%h exp=0", outs()); end
    total++; if ({dut.r_wcnt, dut.r_rcnt, dut.r_fcnt} !== 12'h0) begin bad++; $display("FAIL rm_counters got=%h exp=0", {dut.r_wcnt, dut.r_rcnt, dut.r_fcnt}); end
    @(negedge clk); #1;
    total++; if ({reg_req.aw_valid, mem_req.aw_valid, host_resp.aw_ready, host_resp.w_ready} !== 4'b1010) begin bad++; $display("FAIL rm_fresh_aw got=%b exp=1010", {reg_req.aw_valid, mem_req.aw_valid, host_resp.aw_ready, host_resp.w_ready}); end
    @(negedge clk); idle();
  endtask
  initial begin
    test_reset();
    test_routing();
    test_lock();
    test_full();
    test_w_order();
    test_window();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
